mem_arbiter: RTL and testbench

//  Shares the single-port main memory model between the I-cache (read-only fills) and the
//  D-cache (fills and dirty write-backs). Sits between the cache miss logic and memory.
//  One transaction in flight; adds a programmable access latency before issuing to memory.

---
 rtl/mem_arbiter.sv | 130 +++++++++++++
 tb/tb_mem_arbiter.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shares single-port main memory between I-cache fills and D-cache fills/write-backs
// One transaction in flight, programmable pre-issue latency, round-robin on ties.
module mem_arbiter #(
    parameter int LATENCY = 5,
    parameter int ADDR_W  = 32,
    parameter int LINE_W  = 128
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ic_req_ren,
    input  logic [ADDR_W-1:0] ic_req_raddr,
    output logic              ic_rec_en,
    output logic [LINE_W-1:0] ic_rec_cacheline,
    input  logic              dc_req_ren,
    input  logic [ADDR_W-1:0] dc_req_raddr,
    input  logic              dc_req_wen,
    input  logic [ADDR_W-1:0] dc_req_waddr,
    input  logic [LINE_W-1:0] dc_req_wcacheline,
    output logic              dc_rec_en,
    output logic [LINE_W-1:0] dc_rec_cacheline,
    output logic              dc_wack,
    output logic              mem_req_ren,
    output logic [ADDR_W-1:0] mem_req_raddr,
    output logic              mem_req_wen,
    output logic [ADDR_W-1:0] mem_req_waddr,
    output logic [LINE_W-1:0] mem_req_wcacheline,
    input  logic              mem_rec_en,
    input  logic [ADDR_W-1:0] mem_rec_addr,
    input  logic [LINE_W-1:0] mem_rec_cacheline,
    output logic              busy
);
    localparam int CNT_W = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ISSUE, S_RESP} state_t;
    typedef enum logic {OWN_IC = 1'b0, OWN_DC = 1'b1} owner_t;

    state_t              state_q;
    owner_t              owner_q, rr_last_q, owner_d;
    logic [CNT_W-1:0]    cnt_q;
    logic                wr_q, wr_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [LINE_W-1:0]   wdata_q;
    logic                mem_ren_q, mem_wen_q, wack_q;
    logic                grant;

    // D-cache takes a tie unless it was the last owner; its write-back precedes its fill.
    always_comb begin
        grant   = ic_req_ren | dc_req_wen | dc_req_ren;
        owner_d = OWN_IC;
        if ((dc_req_wen | dc_req_ren) && (!ic_req_ren || rr_last_q == OWN_IC)) begin
            owner_d = OWN_DC;
        end
        wr_d   = (owner_d == OWN_DC) && dc_req_wen;
        addr_d = ic_req_raddr;
        if (owner_d == OWN_DC) begin
            addr_d = dc_req_wen ? dc_req_waddr : dc_req_raddr;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            rr_last_q <= OWN_IC;
            owner_q   <= OWN_IC;
            wr_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            mem_ren_q <= 1'b0;
            mem_wen_q <= 1'b0;
            wack_q    <= 1'b0;
        end else begin
            mem_ren_q <= 1'b0;
            mem_wen_q <= 1'b0;
            wack_q    <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (grant) begin
                        owner_q   <= owner_d;
                        rr_last_q <= owner_d;
                        wr_q      <= wr_d;
                        addr_q    <= addr_d;
                        wdata_q   <= dc_req_wcacheline;
                        cnt_q     <= CNT_W'(LATENCY);
                        if (LATENCY > 0) begin
                            state_q <= S_WAIT;
                        end else begin
                            state_q   <= S_ISSUE;
                            mem_ren_q <= !wr_d;
                            mem_wen_q <= wr_d;
                            wack_q    <= wr_d;
                        end
                    end
                end
                S_WAIT: begin
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_q   <= S_ISSUE;
                        mem_ren_q <= !wr_q;
                        mem_wen_q <= wr_q;
                        wack_q    <= wr_q;
                    end
                end
                S_ISSUE: state_q <= wr_q ? S_IDLE : S_RESP;
                S_RESP: begin
                    if (mem_rec_en) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign mem_req_ren        = mem_ren_q;
    assign mem_req_wen        = mem_wen_q;
    assign mem_req_raddr      = addr_q;
    assign mem_req_waddr      = addr_q;
    assign mem_req_wcacheline = wdata_q;
    assign dc_wack            = wack_q;
    assign ic_rec_en          = (state_q == S_RESP) && (owner_q == OWN_IC) && mem_rec_en;
    assign dc_rec_en          = (state_q == S_RESP) && (owner_q == OWN_DC) && mem_rec_en;
    assign ic_rec_cacheline   = mem_rec_cacheline;
    assign dc_rec_cacheline   = mem_rec_cacheline;
    assign busy               = (state_q != S_IDLE);

    a_resp_addr: assert property (@(posedge clk) disable iff (rst)
        (state_q == S_RESP && mem_rec_en) |-> (mem_rec_addr == addr_q));

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter (LATENCY=5 main instance, LATENCY=0 timing instance)
// Expected memory/requester events are queued at stimulus time with their cycle and popped as the DUT emits them.
module tb_mem_arbiter;
    localparam int AW = 32;
    localparam int LW = 128;

    typedef enum int {K_MRD, K_MWR, K_WACK, K_ICR, K_DCR} kind_t;
    typedef struct {
        kind_t       kind;
        logic [31:0] addr;
        logic [127:0] data;
        int          cyc;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    ev_t  sb[$];

    logic          ic_req_ren = 0, dc_req_ren = 0, dc_req_wen = 0;
    logic [AW-1:0] ic_req_raddr = 0, dc_req_raddr = 0, dc_req_waddr = 0;
    logic [LW-1:0] dc_req_wcacheline = 0;
    logic          ic_rec_en, dc_rec_en, dc_wack, mem_req_ren, mem_req_wen, busy;
    logic [LW-1:0] ic_rec_cacheline, dc_rec_cacheline, mem_req_wcacheline;
    logic [AW-1:0] mem_req_raddr, mem_req_waddr;
    logic          mdl_en = 0, spur_en = 0;
    logic [AW-1:0] mdl_addr = 0;
    logic [LW-1:0] mdl_line = 0;
    logic          mem_rec_en;
    logic [AW-1:0] mem_rec_addr;
    logic [LW-1:0] mem_rec_cacheline;

    logic          ic_req_ren0 = 0;
    logic          ic_rec_en0, dc_rec_en0, dc_wack0, mem_req_ren0, mem_req_wen0, busy0;
    logic [LW-1:0] ic_rec_cacheline0, dc_rec_cacheline0, mem_req_wcacheline0;
    logic [AW-1:0] mem_req_raddr0, mem_req_waddr0;
    logic          mem_rec_en0 = 0;
    logic [AW-1:0] mem_rec_addr0 = 0;
    logic [LW-1:0] mem_rec_cacheline0 = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [LW-1:0] line_of(input logic [AW-1:0] a);
        return {a, ~a, a ^ 32'h5A5A_5A5A, a + 32'h1111_0000};
    endfunction

    always @(posedge clk) begin
        mdl_en   <= mem_req_ren;
        mdl_addr <= mem_req_raddr;
        mdl_line <= line_of(mem_req_raddr);
        mem_rec_en0        <= mem_req_ren0;
        mem_rec_addr0      <= mem_req_raddr0;
        mem_rec_cacheline0 <= line_of(mem_req_raddr0);
    end
    assign mem_rec_en        = mdl_en | spur_en;
    assign mem_rec_addr      = spur_en ? 32'hDEAD_0000 : mdl_addr;
    assign mem_rec_cacheline = spur_en ? '1 : mdl_line;

    mem_arbiter #(.LATENCY(5), .ADDR_W(AW), .LINE_W(LW)) dut (
        .clk(clk), .rst(rst),
        .ic_req_ren(ic_req_ren), .ic_req_raddr(ic_req_raddr),
        .ic_rec_en(ic_rec_en), .ic_rec_cacheline(ic_rec_cacheline),
        .dc_req_ren(dc_req_ren), .dc_req_raddr(dc_req_raddr),
        .dc_req_wen(dc_req_wen), .dc_req_waddr(dc_req_waddr),
        .dc_req_wcacheline(dc_req_wcacheline),
        .dc_rec_en(dc_rec_en), .dc_rec_cacheline(dc_rec_cacheline), .dc_wack(dc_wack),
        .mem_req_ren(mem_req_ren), .mem_req_raddr(mem_req_raddr),
        .mem_req_wen(mem_req_wen), .mem_req_waddr(mem_req_waddr),
        .mem_req_wcacheline(mem_req_wcacheline),
        .mem_rec_en(mem_rec_en), .mem_rec_addr(mem_rec_addr),
        .mem_rec_cacheline(mem_rec_cacheline), .busy(busy)
    );

    mem_arbiter #(.LATENCY(0), .ADDR_W(AW), .LINE_W(LW)) dut0 (
        .clk(clk), .rst(rst),
        .ic_req_ren(ic_req_ren0), .ic_req_raddr(32'h0000_0040),
        .ic_rec_en(ic_rec_en0), .ic_rec_cacheline(ic_rec_cacheline0),
        .dc_req_ren(1'b0), .dc_req_raddr(32'h0),
        .dc_req_wen(1'b0), .dc_req_waddr(32'h0),
        .dc_req_wcacheline(128'h0),
        .dc_rec_en(dc_rec_en0), .dc_rec_cacheline(dc_rec_cacheline0), .dc_wack(dc_wack0),
        .mem_req_ren(mem_req_ren0), .mem_req_raddr(mem_req_raddr0),
        .mem_req_wen(mem_req_wen0), .mem_req_waddr(mem_req_waddr0),
        .mem_req_wcacheline(mem_req_wcacheline0),
        .mem_rec_en(mem_rec_en0), .mem_rec_addr(mem_rec_addr0),
        .mem_rec_cacheline(mem_rec_cacheline0), .busy(busy0)
    );

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push(input kind_t k, input logic [31:0] a, input logic [127:0] d, input int c);
        ev_t e;
        e.kind = k; e.addr = a; e.data = d; e.cyc = c;
        sb.push_back(e);
    endtask

    task automatic pop_chk(input kind_t k, input logic [31:0] a, input logic [127:0] d);
        ev_t e;
        if (sb.size() == 0) begin
            chk($sformatf("unexpected_event_k%0d_cyc%0d", k, cyc), 128'(sb.size()), 128'd1);
        end else begin
            e = sb.pop_front();
            chk("ev_kind", 128'(k), 128'(e.kind));
            chk("ev_cycle", 128'(cyc), 128'(e.cyc));
            chk("ev_addr", 128'(a), 128'(e.addr));
            chk("ev_data", d, e.data);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (mem_req_wen) pop_chk(K_MWR, mem_req_waddr, mem_req_wcacheline);
            if (mem_req_ren) pop_chk(K_MRD, mem_req_raddr, 128'h0);
            if (dc_wack)     pop_chk(K_WACK, 32'h0, 128'h0);
            if (ic_rec_en)   pop_chk(K_ICR, 32'h0, ic_rec_cacheline);
            if (dc_rec_en)   pop_chk(K_DCR, 32'h0, dc_rec_cacheline);
        end
    end

    // Requesters drop their request on the edge that samples the matching pulse.
    task automatic run_until_quiet(input int budget);
        logic fi, fd, fw, b;
        logic done;
        done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            @(negedge clk);
            fi = ic_rec_en; fd = dc_rec_en; fw = dc_wack; b = busy;
            @(posedge clk); #1;
            if (fi) ic_req_ren = 1'b0;
            if (fd) dc_req_ren = 1'b0;
            if (fw) dc_req_wen = 1'b0;
            if (!ic_req_ren && !dc_req_ren && !dc_req_wen && !b && !fi && !fd && !fw) done = 1'b1;
        end
        chk("quiet_before_timeout", 128'(done), 128'd1);
    endtask

    int c;
    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 128'(busy), 128'd0);
        chk("rst_mem_ren", 128'(mem_req_ren), 128'd0);
        chk("rst_mem_wen", 128'(mem_req_wen), 128'd0);
        chk("rst_wack", 128'(dc_wack), 128'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        c = cyc;
        ic_req_ren = 1; ic_req_raddr = 32'h1240;
        push(K_MRD, 32'h1240, 128'h0, c + 6);
        push(K_ICR, 32'h0, line_of(32'h1240), c + 7);
        run_until_quiet(40);

        for (int t = 0; t < 2; t++) begin
            c = cyc;
            dc_req_ren = 1; dc_req_raddr = 32'h3100 + t * 32'h40;
            ic_req_ren = 1; ic_req_raddr = 32'h1300 + t * 32'h40;
            push(K_MRD, dc_req_raddr, 128'h0, c + 6);
            push(K_DCR, 32'h0, line_of(dc_req_raddr), c + 7);
            push(K_MRD, ic_req_raddr, 128'h0, c + 14);
            push(K_ICR, 32'h0, line_of(ic_req_raddr), c + 15);
            run_until_quiet(60);
        end

        c = cyc;
        dc_req_wen = 1; dc_req_waddr = 32'h2000;
        dc_req_wcacheline = 128'hCAFE_0001_BEEF_0002_F00D_0003_ABCD_0004;
        dc_req_ren = 1; dc_req_raddr = 32'h3000;
        push(K_MWR, 32'h2000, dc_req_wcacheline, c + 6);
        push(K_WACK, 32'h0, 128'h0, c + 6);
        push(K_MRD, 32'h3000, 128'h0, c + 13);
        push(K_DCR, 32'h0, line_of(32'h3000), c + 14);
        run_until_quiet(60);

        ic_req_ren = 1; ic_req_raddr = 32'h1400;
        repeat (2) begin @(posedge clk); #1; end
        rst = 1; ic_req_ren = 0;
        #1;
        chk("rst_wait_busy", 128'(busy), 128'd0);
        chk("rst_wait_mem_ren", 128'(mem_req_ren), 128'd0);
        @(posedge clk); #1;
        rst = 0;
        repeat (10) begin @(posedge clk); #1; end

        c = cyc;
        ic_req_ren = 1; ic_req_raddr = 32'h1500;
        push(K_MRD, 32'h1500, 128'h0, c + 6);
        repeat (7) begin @(posedge clk); #1; end
        chk("resp_busy_before_rst", 128'(busy), 128'd1);
        rst = 1; ic_req_ren = 0;
        #1;
        chk("rst_resp_busy", 128'(busy), 128'd0);
        chk("rst_resp_late_mem", 128'(mem_rec_en), 128'd1);
        chk("rst_resp_ic_rec", 128'(ic_rec_en), 128'd0);
        chk("rst_resp_dc_rec", 128'(dc_rec_en), 128'd0);
        @(posedge clk); #1;
        rst = 0;
        repeat (3) begin @(posedge clk); #1; end

        spur_en = 1;
        @(negedge clk);
        chk("spur_ic_rec", 128'(ic_rec_en), 128'd0);
        chk("spur_dc_rec", 128'(dc_rec_en), 128'd0);
        @(posedge clk); #1;
        spur_en = 0;
        chk("spur_busy", 128'(busy), 128'd0);
        repeat (2) begin @(posedge clk); #1; end

        ic_req_ren0 = 1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk($sformatf("lat0_busy_c%0d", k), 128'(busy0), 128'(k == 1 || k == 2));
            chk($sformatf("lat0_mem_ren_c%0d", k), 128'(mem_req_ren0), 128'(k == 1));
            chk($sformatf("lat0_ic_rec_c%0d", k), 128'(ic_rec_en0), 128'(k == 2));
            if (k == 2) chk("lat0_data", ic_rec_cacheline0, line_of(32'h40));
            @(posedge clk); #1;
            if (k == 2) ic_req_ren0 = 0;
        end

        chk("sb_empty", 128'(sb.size()), 128'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
